// File: rtl/board_vram_arbiter.sv
// Board-state RAM arbiter: the VGA scan reads cells, queued game writes drain when the scan is off-board.
// Optional cursor highlight is built only when BOARD_CURSOR_EN is defined.
module board_vram_arbiter #(
    parameter int BOARD_N    = 15,
    parameter int CELL_LOG2  = 5,
    parameter int X0         = 80,
    parameter int Y0         = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    input  logic        wr_req,
    input  logic [3:0]  wr_x,
    input  logic [3:0]  wr_y,
    input  logic [1:0]  wr_data,
    output logic        wr_ready,
    output logic        wr_err,
    output logic [7:0]  mem_addr,
    output logic        mem_we,
    output logic [1:0]  mem_wdata,
    input  logic [1:0]  mem_rdata,
    output logic [11:0] d_out,
    input  logic [3:0]  cur_x,
    input  logic [3:0]  cur_y
);
    // FIFO_DEPTH is a power of 2 (>= 2) so the pointers wrap on their own.
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [9:0] SPAN = 10'(BOARD_N << CELL_LOG2);

    logic [9:0]  w_col_off, w_row_off;
    logic [3:0]  w_cx, w_cy;
    logic        w_in_board, w_grid;
    logic [7:0]  w_scan_addr;

    // Offsets wrap at 10 bits, so anything left/above the board lands >= SPAN.
    assign w_col_off   = col_addr - 10'(X0);
    assign w_row_off   = {1'b0, row_addr} - 10'(Y0);
    assign w_in_board  = !rdn && (w_col_off < SPAN) && (w_row_off < SPAN);
    assign w_cx        = 4'(w_col_off >> CELL_LOG2);
    assign w_cy        = 4'(w_row_off >> CELL_LOG2);
    assign w_grid      = (w_col_off[CELL_LOG2-1:0] == '0) || (w_row_off[CELL_LOG2-1:0] == '0);
    assign w_scan_addr = 8'(int'(w_cy) * BOARD_N + int'(w_cx));

`ifdef BOARD_CURSOR_EN
    logic w_cur;
    logic r_s1_cur;
    assign w_cur = (w_cx == cur_x) && (w_cy == cur_y) && w_grid;
`else
    logic w_unused_cur;
    assign w_unused_cur = ^{cur_x, cur_y};
`endif

    logic [7:0]       r_fifo_addr [FIFO_DEPTH];
    logic [1:0]       r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full, w_empty, w_wr_bad, w_accept, w_push, w_pop;
    logic [7:0]       w_wr_addr;
    logic             r_wr_err;

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_wr_bad  = (int'(wr_x) >= BOARD_N) || (int'(wr_y) >= BOARD_N);
    assign w_wr_addr = 8'(int'(wr_y) * BOARD_N + int'(wr_x));
    assign w_accept  = wr_req && !w_full;
    assign w_push    = w_accept && !w_wr_bad;
    assign w_pop     = !w_in_board && !w_empty;
    assign wr_ready  = !w_full;
    assign wr_err    = r_wr_err;

    always_ff @(posedge vga_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= w_wr_addr;
            r_fifo_data[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_accept && w_wr_bad;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The scan always wins the port; the idle port parks on the last address.
    logic [7:0] r_addr;
    logic [7:0] w_mem_addr;
    logic       w_mem_we;
    logic [1:0] w_mem_wdata;

    always_comb begin
        w_mem_addr  = r_addr;
        w_mem_we    = 1'b0;
        w_mem_wdata = 2'b00;
        if (w_in_board) begin
            w_mem_addr = w_scan_addr;
        end else if (!w_empty) begin
            w_mem_addr  = r_fifo_addr[r_rd_ptr];
            w_mem_we    = 1'b1;
            w_mem_wdata = r_fifo_data[r_rd_ptr];
        end
    end

    assign mem_addr  = w_mem_addr;
    assign mem_we    = w_mem_we;
    assign mem_wdata = w_mem_wdata;

    logic        r_s1_vld, r_s1_in, r_s1_grid, r_s1_rdn;
    logic [11:0] w_colour, r_d_out;

    always_comb begin
        w_colour = 12'h000;
        if (r_s1_rdn)      w_colour = 12'h000;
        else if (!r_s1_in) w_colour = 12'h444;
        else begin
            case (mem_rdata)
                2'd1:    w_colour = 12'h111;
                2'd2:    w_colour = 12'hEEE;
                2'd3:    w_colour = 12'h00F;
                default: w_colour = r_s1_grid ? 12'h000 : 12'h38C;
            endcase
`ifdef BOARD_CURSOR_EN
            if (r_s1_cur) w_colour = 12'h0F0;
`endif
        end
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_addr    <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_in   <= 1'b0;
            r_s1_grid <= 1'b0;
            r_s1_rdn  <= 1'b1;
`ifdef BOARD_CURSOR_EN
            r_s1_cur  <= 1'b0;
`endif
            r_d_out   <= '0;
        end else begin
            r_addr    <= w_mem_addr;
            r_s1_vld  <= 1'b1;
            r_s1_in   <= w_in_board;
            r_s1_grid <= w_grid;
            r_s1_rdn  <= rdn;
`ifdef BOARD_CURSOR_EN
            r_s1_cur  <= w_cur;
`endif
            // Stage 1 holds nothing meaningful on the first cycle out of reset.
            r_d_out   <= r_s1_vld ? w_colour : 12'h000;
        end
    end

    assign d_out = r_d_out;
endmodule

// File: tb/tb_board_vram_arbiter.sv
// Scoreboard bench for board_vram_arbiter: directed scans and writes against a behavioural sync RAM.
module tb_board_vram_arbiter;
    logic        vga_clk = 1'b0;
    logic        clrn;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        rdn;
    logic        wr_req;
    logic [3:0]  wr_x, wr_y;
    logic [1:0]  wr_data;
    logic        wr_ready, wr_err, mem_we;
    logic [7:0]  mem_addr;
    logic [1:0]  mem_wdata;
    logic [1:0]  mem_rdata = 2'b00;
    logic [11:0] d_out;
    logic [3:0]  cur_x, cur_y;

    board_vram_arbiter dut (
        .vga_clk(vga_clk), .clrn(clrn), .row_addr(row_addr), .col_addr(col_addr), .rdn(rdn),
        .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ready(wr_ready),
        .wr_err(wr_err), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .d_out(d_out), .cur_x(cur_x), .cur_y(cur_y)
    );

    always #5 vga_clk = ~vga_clk;

    logic [1:0] ram [256] = '{default: 2'b00};
    always @(posedge vga_clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [11:0] want; } pix_t;
    pix_t        q_pix [$];
    logic [9:0]  q_wr  [$];
    int          q_err [$];
    int n_vec = 0;
    int n_err = 0;

`ifdef BOARD_CURSOR_EN
    localparam logic [11:0] C00 = 12'h0F0;
`else
    localparam logic [11:0] C00 = 12'h111;
`endif

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a pixel, a RAM write or an error pulse.
    always @(negedge vga_clk) begin
        if (clrn === 1'b1) begin
            if (q_pix.size() > 0 && q_pix[0].cyc + 2 == cyc) begin
                pix_t e;
                e = q_pix.pop_front();
                chk("pixel", d_out, e.want);
            end
            if (mem_we) begin
                if (q_wr.size() == 0) chk("unexpected_we", {mem_addr, mem_wdata}, 32'hFFFF);
                else begin
                    logic [9:0] w;
                    w = q_wr.pop_front();
                    chk("write_addr_data", {mem_addr, mem_wdata}, w);
                end
            end
            if (wr_err) begin
                if (q_err.size() == 0) chk("unexpected_err", 1, 0);
                else begin
                    int c;
                    c = q_err.pop_front();
                    chk("err_cycle", cyc, c);
                end
            end
        end
    end

    logic       pend = 1'b0;
    logic [3:0] p_x, p_y, g_cx = 4'd15, g_cy = 4'd15;
    logic [1:0] p_d;
    logic [7:0] p_addr;

    task automatic set_wr(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d, input logic [7:0] a);
        pend = 1'b1; p_x = x; p_y = y; p_d = d; p_addr = a;
    endtask

    task automatic tick(input logic [8:0] r, input logic [9:0] c, input logic rd, input logic [11:0] want);
        @(posedge vga_clk); #1;
        row_addr = r; col_addr = c; rdn = rd;
        wr_req = pend; wr_x = p_x; wr_y = p_y; wr_data = p_d;
        cur_x = g_cx; cur_y = g_cy;
        q_pix.push_back('{cyc: cyc, want: want});
        @(negedge vga_clk);
        if (wr_req && wr_ready) begin
            if (p_x >= 4'd15 || p_y >= 4'd15) q_err.push_back(cyc + 1);
            else q_wr.push_back({p_addr, p_d});
            pend = 1'b0;
        end
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) tick(9'd480, 10'd0, 1'b1, 12'h000);
    endtask

    logic [3:0] fx [5] = '{4'd0, 4'd1, 4'd14, 4'd2, 4'd7};
    logic [3:0] fy [5] = '{4'd0, 4'd0, 4'd14, 4'd1, 4'd7};
    logic [1:0] fd [5] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    logic [7:0] fa [5] = '{8'd0, 8'd1, 8'd224, 8'd17, 8'd112};

    initial begin
        clrn = 1'b0; row_addr = 9'd480; col_addr = 10'd0; rdn = 1'b1;
        wr_req = 1'b0; wr_x = 4'd0; wr_y = 4'd0; wr_data = 2'd0; cur_x = 4'd15; cur_y = 4'd15;
        p_x = 4'd0; p_y = 4'd0; p_d = 2'd0; p_addr = 8'd0;
        repeat (3) @(negedge vga_clk);
        chk("reset_dout", d_out, 12'h000);
        chk("reset_ready", wr_ready, 1);
        chk("reset_we", mem_we, 0);
        chk("reset_err", wr_err, 0);
        chk("reset_addr", mem_addr, 0);
        @(posedge vga_clk); #1 clrn = 1'b1;

        tick(9'd10, 10'd200, 1'b0, 12'h38C);
        blank(2);

        // write during blanking lands on the next cycle
        set_wr(4'd3, 4'd4, 2'd1, 8'd63);
        blank(1);
        blank(1);
        chk("blank_we", mem_we, 1);
        chk("blank_addr", mem_addr, 63);
        chk("blank_wdata", mem_wdata, 1);
        blank(1);
        chk("blank_drained", mem_we, 0);

        // write during the board is deferred to the first off-board cycle
        set_wr(4'd3, 4'd4, 2'd1, 8'd63);
        for (int i = 0; i < 4; i++) begin
            tick(9'd100, 10'd100, 1'b0, 12'h38C);
            chk("defer_we_low", mem_we, 0);
        end
        blank(1);
        chk("defer_we", mem_we, 1);
        chk("defer_addr", mem_addr, 63);
        blank(1);
        chk("defer_drained", mem_we, 0);
        tick(9'd138, 10'd186, 1'b0, 12'h111);
        blank(2);

        // fill the FIFO on board pixels, fifth write held until blanking
        for (int i = 0; i < 4; i++) begin
            set_wr(fx[i], fy[i], fd[i], fa[i]);
            tick(9'd100, 10'd100, 1'b0, 12'h38C);
            chk("full_accept", pend, 0);
        end
        set_wr(fx[4], fy[4], fd[4], fa[4]);
        for (int i = 0; i < 3; i++) begin
            tick(9'd100, 10'd100, 1'b0, 12'h38C);
            chk("full_ready_low", wr_ready, 0);
            chk("full_held", pend, 1);
            chk("full_we_low", mem_we, 0);
        end
        blank(1);
        chk("drain0_ready", wr_ready, 0);
        chk("drain0_we", mem_we, 1);
        blank(1);
        chk("drain1_ready", wr_ready, 1);
        chk("fifth_accept", pend, 0);
        blank(6);
        chk("full_all_landed", q_wr.size(), 0);

        g_cx = 4'd0; g_cy = 4'd0;
        tick(9'd0, 10'd80, 1'b0, C00);
        g_cx = 4'd15; g_cy = 4'd15;
        tick(9'd479, 10'd559, 1'b0, 12'h00F);
        tick(9'd229, 10'd309, 1'b0, 12'hEEE);
        tick(9'd40, 10'd152, 1'b0, 12'h111);
        tick(9'd32, 10'd200, 1'b0, 12'h000);
        tick(9'd100, 10'd79, 1'b0, 12'h444);
        tick(9'd100, 10'd560, 1'b0, 12'h444);
        tick(9'd480, 10'd300, 1'b1, 12'h000);
        blank(2);

        // out-of-range coordinates: accepted, error pulse, nothing written
        set_wr(4'd15, 4'd2, 2'd1, 8'd0);
        blank(1);
        chk("bad_accept", pend, 0);
        blank(1);
        chk("bad_err_pulse", wr_err, 1);
        chk("bad_no_we", mem_we, 0);
        blank(1);
        chk("bad_err_clear", wr_err, 0);

        // reset in the middle of queued writes
        set_wr(4'd5, 4'd5, 2'd2, 8'd80);
        tick(9'd100, 10'd100, 1'b0, 12'h38C);
        set_wr(4'd6, 4'd6, 2'd2, 8'd96);
        tick(9'd100, 10'd100, 1'b0, 12'h38C);
        tick(9'd100, 10'd100, 1'b0, 12'h38C);
        chk("pre_reset_dout", d_out, 12'h38C);
        @(posedge vga_clk); #1;
        clrn = 1'b0; rdn = 1'b1; row_addr = 9'd480; wr_req = 1'b0;
        #1;
        chk("midrst_dout", d_out, 12'h000);
        chk("midrst_ready", wr_ready, 1);
        chk("midrst_we", mem_we, 0);
        q_pix.delete(); q_wr.delete(); q_err.delete();
        repeat (2) @(posedge vga_clk);
        #1 clrn = 1'b1;
        blank(4);
        tick(9'd170, 10'd250, 1'b0, 12'h38C);
        blank(2);
        repeat (3) @(negedge vga_clk);

        chk("end_q_wr", q_wr.size(), 0);
        chk("end_q_err", q_err.size(), 0);
        chk("end_q_pix", q_pix.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
